i2c_master: RTL and testbench

//  Single-master I2C initiator: drives the bus opposite i2c_slave.

---
 rtl/i2c_master.sv | 121 ++++++++++++
 tb/tb_i2c_master.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master.sv
// i2c_master: single-master I2C initiator, one 7-bit-addressed single-byte transfer per start pulse
// Ports: clk, rst_n (synchronous, active-low)
//        start, rw, addr[6:0], wdata[7:0]  transaction request, captured when accepted
//        rdata[7:0], busy, done, ack_err    status back to the host
//        scl, sda_out                       bus drives, 1 = released/high
//        sda_in                             asynchronous SDA pad input
module i2c_master #(
    parameter int QDIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    input  logic       sda_in,
    output logic       sda_out
);
    typedef enum logic [3:0] {
        IDLE, START_C, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_NACK, STOP_C, DONE
    } state_t;

    localparam logic [7:0] QMAX = 8'(QDIV - 1);

    state_t     state, nxt;
    logic [7:0] qc, abyte, dbyte, shreg;
    logic [1:0] q;
    logic [2:0] bc;
    logic       s1, s2, step_end, bit_st, idle_like;

    // step_end marks the last clk of quarter Q3, where SDA is sampled and the state advances
    assign step_end  = qc == QMAX && q == 2'd3;
    assign bit_st    = state inside {ADDR, WDATA, RDATA};
    assign idle_like = state inside {IDLE, DONE};
    assign busy      = !idle_like;
    assign done      = state == DONE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            qc      <= 8'd0;
            q       <= 2'd0;
            bc      <= 3'd7;
            abyte   <= 8'd0;
            dbyte   <= 8'd0;
            shreg   <= 8'd0;
            rdata   <= 8'd0;
            ack_err <= 1'b0;
            s1      <= 1'b1;
            s2      <= 1'b1;
        end else begin
            state <= nxt;
            s1    <= sda_in;
            s2    <= s1;
            if (idle_like) begin
                qc <= 8'd0;
                q  <= 2'd0;
                bc <= 3'd7;
            end else begin
                qc <= qc == QMAX ? 8'd0 : qc + 8'd1;
                if (qc == QMAX) q <= q + 2'd1;
            end
            if (state == IDLE && start) begin
                abyte   <= {addr, rw};
                dbyte   <= wdata;
                ack_err <= 1'b0;
            end
            if (step_end) begin
                bc <= bit_st && bc != 3'd0 ? bc - 3'd1 : 3'd7;
                if (state inside {ADDR_ACK, WDATA_ACK} && s2) ack_err <= 1'b1;
                if (state == RDATA) shreg <= {shreg[6:0], s2};
                // a read only reaches STOP_C error-free if the address was ACKed
                if (state == STOP_C && abyte[0] && !ack_err) rdata <= shreg;
            end
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:       nxt = start ? START_C : IDLE;
            START_C:    nxt = step_end ? ADDR : START_C;
            ADDR:       nxt = step_end && bc == 3'd0 ? ADDR_ACK : ADDR;
            ADDR_ACK:   nxt = !step_end ? ADDR_ACK : s2 ? STOP_C : abyte[0] ? RDATA : WDATA;
            WDATA:      nxt = step_end && bc == 3'd0 ? WDATA_ACK : WDATA;
            WDATA_ACK:  nxt = step_end ? STOP_C : WDATA_ACK;
            RDATA:      nxt = step_end && bc == 3'd0 ? RDATA_NACK : RDATA;
            RDATA_NACK: nxt = step_end ? STOP_C : RDATA_NACK;
            STOP_C:     nxt = step_end ? DONE : STOP_C;
            DONE:       nxt = IDLE;
            default:    nxt = IDLE;
        endcase
    end

    always_comb begin
        scl     = 1'b1;
        sda_out = 1'b1;
        case (state)
            START_C: sda_out = !q[1];
            ADDR: begin
                scl     = q[1];
                sda_out = abyte[bc];
            end
            WDATA: begin
                scl     = q[1];
                sda_out = dbyte[bc];
            end
            ADDR_ACK, WDATA_ACK, RDATA, RDATA_NACK: scl = q[1];
            STOP_C: begin
                scl     = q != 2'd0;
                sda_out = q[1];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: randomized scoreboard bench for i2c_master with a behavioural ACKing slave at 0x51
module tb_i2c_master;
    localparam int QDIV = 2;

    logic       clk = 0, rst_n = 0, start = 0, rw = 0;
    logic [6:0] addr = 0;
    logic [7:0] wdata = 0;
    logic [7:0] rdata;
    logic       busy, done, ack_err, scl, sda_out, sda_in;
    logic       sl_sda = 1;

    assign sda_in = sda_out & sl_sda;

    i2c_master #(.QDIV(QDIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy(busy), .done(done), .ack_err(ack_err),
        .scl(scl), .sda_in(sda_in), .sda_out(sda_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    typedef struct {int due; logic ae; logic [7:0] rd;} done_t;
    typedef struct {logic [17:0] bits; int n;} bus_t;
    done_t dq[$];
    bus_t  bq[$];

    logic [7:0] sb = 0;
    logic [7:0] exp_rd = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected bus content: address byte, address ack, then either the data byte and its
    // ack/nack or nothing; the last bit of an ACKed transfer is the slave ACK (write) or master NACK (read).
    task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] d);
        bit    ack = (a == 7'h51);
        bus_t  b;
        done_t e;
        addr  = a;
        rw    = r;
        wdata = d;
        start = 1;
        if (ack && r) exp_rd = sb;
        b.n    = ack ? 18 : 9;
        b.bits = ack ? {a, r, 1'b0, (r ? sb : d), r} : {9'b0, a, r, 1'b1};
        e.due  = cyc + 1 + (ack ? 80 : 44) * QDIV;
        e.ae   = !ack;
        e.rd   = exp_rd;
        dq.push_back(e);
        bq.push_back(b);
        step();
        start = 0;
        addr  = 7'($urandom);
        rw    = 1'($urandom);
        wdata = 8'($urandom);
        chk("busy_after_accept", {31'b0, busy}, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 2000) begin
            step();
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wait_done: done=%0b expected 1 within 2000 cycles", done);
        end
    endtask

    // Done monitor: every done pulse must match the oldest outstanding expectation.
    initial begin : mon
        done_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no done at cycle %0d", cyc);
                end else begin
                    e = dq.pop_front();
                    chk("done_cycle", cyc, e.due);
                    chk("ack_err", {31'b0, ack_err}, {31'b0, e.ae});
                    chk("rdata", {24'b0, rdata}, {24'b0, e.rd});
                    chk("busy_at_done", {31'b0, busy}, 0);
                end
            end
        end
    end

    // Bus monitor and slave: bits clocked on SCL rises; the slave changes SDA on SCL falls.
    logic       ps = 1, pd = 1, act = 0, match = 0, rd_b = 0, bsda;
    logic [18:0] got = 0;
    int          nb = 0;
    initial begin : bus
        bus_t e;
        forever begin
            @(negedge clk);
            bsda = sda_out & sl_sda;
            if (ps && scl && pd && !bsda) begin
                act    = 1;
                nb     = 0;
                got    = 0;
                sl_sda = 1;
            end else if (act && ps && scl && !pd && bsda) begin
                act = 0;
                if (bq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_stop: got STOP expected none at cycle %0d", cyc);
                end else begin
                    // the STOP's own SCL rise was clocked in as a bit; drop it
                    e = bq.pop_front();
                    chk("bus_nbits", nb - 1, e.n);
                    chk("bus_bits", {13'b0, got} >> 1, {14'b0, e.bits});
                end
            end else if (act && !ps && scl) begin
                got = {got[17:0], bsda};
                nb++;
            end else if (act && ps && !scl) begin
                if (nb == 8) begin
                    match = got[7:1] == 7'h51;
                    rd_b  = got[0];
                end
                sl_sda = nb == 8 ? !match :
                         (match && rd_b && nb >= 9 && nb <= 16) ? sb[16 - nb] :
                         (nb == 17 && match && !rd_b) ? 1'b0 : 1'b1;
            end
            ps = scl;
            pd = sda_out & sl_sda;
        end
    end

    initial begin
        repeat (3) step();
        chk("reset_scl", {31'b0, scl}, 1);
        chk("reset_sda", {31'b0, sda_out}, 1);
        chk("reset_busy", {31'b0, busy}, 0);
        chk("reset_done", {31'b0, done}, 0);
        chk("reset_ack_err", {31'b0, ack_err}, 0);
        chk("reset_rdata", {24'b0, rdata}, 0);
        rst_n = 1;
        step();

        sb = 8'h00;
        issue(7'h51, 0, 8'hA5);
        wait_done();
        step();

        issue(7'h30, 0, 8'h77);
        wait_done();
        step();

        sb = 8'h3C;
        issue(7'h51, 1, 8'h00);
        wait_done();
        step();

        issue(7'h51, 0, 8'hA5);
        repeat (19) step();
        start = 1;
        addr  = 7'h30;
        step();
        start = 0;
        wait_done();
        step();

        issue(7'h51, 0, 8'h5A);
        repeat (32) step();
        rst_n = 0;
        step();
        chk("abort_scl", {31'b0, scl}, 1);
        chk("abort_sda", {31'b0, sda_out}, 1);
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_rdata", {24'b0, rdata}, 0);
        dq.delete();
        bq.delete();
        exp_rd = 0;
        rst_n  = 1;
        step();
        issue(7'h51, 0, 8'hC3);
        wait_done();
        step();

        sb = 8'($urandom);
        issue(7'h51, 1, 8'h00);
        wait_done();
        start = 1;
        step();
        start = 0;
        chk("start_in_done_ignored", {31'b0, busy}, 0);
        issue(7'h51, 0, 8'($urandom));
        wait_done();
        step();

        repeat (20) begin
            sb = 8'($urandom);
            issue($urandom_range(0, 1) ? 7'h51 : 7'($urandom), 1'($urandom), 8'($urandom));
            wait_done();
            step();
        end

        repeat (5) step();
        chk("done_queue_empty", dq.size(), 0);
        chk("bus_queue_empty", bq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
